// File: rtl/logic_op_stage.sv
// Handshaked logic-op stage: decodes a 3-bit opcode over two operands and returns the
// result plus status flags through a two-entry (main + skid) output buffer.
module logic_op_stage #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [2:0]           out_op,
    output logic                 out_zero,
    output logic                 out_ones,
    output logic                 out_parity,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       op;
        logic             zero;
        logic             ones;
        logic             parity;
        logic             illegal;
    } entry_t;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    // Result and flags are built together so a held entry can never show stale flags.
    function automatic entry_t compute_entry(input logic [2:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        entry_t e;
        e.op      = op;
        e.illegal = 1'b0;
        case (op)
            OP_NOT:  e.result = ~a;
            OP_AND:  e.result = a & b;
            OP_OR:   e.result = a | b;
            OP_NAND: e.result = ~(a & b);
            OP_NOR:  e.result = ~(a | b);
            OP_XOR:  e.result = a ^ b;
            OP_XNOR: e.result = ~(a ^ b);
            default: begin
                e.result  = '0;
                e.illegal = 1'b1;
            end
        endcase
        e.zero   = (e.result == '0);
        e.ones   = &e.result;
        e.parity = ^e.result;
        return e;
    endfunction

    state_t                 state_q, state_d;
    entry_t                 main_q, main_d;
    entry_t                 skid_q, skid_d;
    logic                   rdy_q, rdy_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    entry_t                 new_entry;
    logic                   valid_w;
    logic                   in_xfer;
    logic                   out_xfer;

    assign new_entry = compute_entry(in_op, in_a, in_b);
    assign valid_w   = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && rdy_q;
    assign out_xfer  = valid_w && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (out_xfer) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = new_entry;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    skid_d  = new_entry;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        rdy_d = (state_d != ST_FULL);
    end

    // Control state is reset; entry payloads are only meaningful while the state says so.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // Holding in_ready low during reset keeps a pending in_valid from looking accepted.
    assign in_ready    = rdy_q && rst_n;
    assign out_valid   = valid_w;
    assign out_result  = valid_w ? main_q.result : '0;
    assign out_op      = valid_w ? main_q.op : 3'd0;
    assign out_zero    = valid_w && main_q.zero;
    assign out_ones    = valid_w && main_q.ones;
    assign out_parity  = valid_w && main_q.parity;
    assign out_illegal = valid_w && main_q.illegal;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_logic_op_stage.sv
// Directed bench for logic_op_stage: a WIDTH=4 instance for function/handshake and a
// CNT_WIDTH=2 instance sharing the same stimulus for counter wrap.
module tb_logic_op_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_result;
    logic [2:0] out_op;
    logic       out_zero, out_ones, out_parity, out_illegal;
    logic [7:0] op_count;

    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] out_result2;
    logic [2:0] out_op2;
    logic       out_zero2, out_ones2, out_parity2, out_illegal2;
    logic [1:0] op_count2;

    int checks = 0;
    int errors = 0;

    logic_op_stage #(.WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
        .out_illegal(out_illegal), .op_count(op_count)
    );

    logic_op_stage #(.WIDTH(4), .CNT_WIDTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid2),
        .out_ready(out_ready), .out_result(out_result2), .out_op(out_op2),
        .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
        .out_illegal(out_illegal2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_res [0:6];
    logic [1:0] exp_wrap [0:4];

    initial begin
        exp_res[0] = 4'b0011; exp_res[1] = 4'b1000; exp_res[2] = 4'b1110;
        exp_res[3] = 4'b0111; exp_res[4] = 4'b0001; exp_res[5] = 4'b0110;
        exp_res[6] = 4'b1001;
        exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3;
        exp_wrap[3] = 2'd0; exp_wrap[4] = 2'd1;

        // Reset held two cycles with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; in_op = 3'd1;
        in_a = 4'b1100; in_b = 4'b1010; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_flags", {out_zero, out_ones, out_parity, out_illegal}, 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // All ops back-to-back, latency 1
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_op = 3'(i);
            tick();
            chk($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("op%0d_result", i), 32'(out_result), 32'(exp_res[i]));
            chk($sformatf("op%0d_op", i), 32'(out_op), 32'(i));
            chk($sformatf("op%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("ops_drained", 32'(out_valid), 32'd0);
        chk("ops_count", 32'(op_count), 32'd7);

        // Backpressure fills main and skid
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd1;
        tick();
        chk("bp1_result", 32'(out_result), 32'b1000);
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        in_op = 3'd2;
        tick();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_result", 32'(out_result), 32'b1000);
        in_op = 3'd3;
        tick();
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_hold", 32'(out_result), 32'b1000);
        chk("bp3_hold_op", 32'(out_op), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain1_result", 32'(out_result), 32'b1110);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2_valid", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(op_count), 32'd9);

        // Simultaneous in/out in ONE
        in_valid = 1'b1; in_op = 3'd5;
        tick();
        chk("sim1_result", 32'(out_result), 32'b0110);
        in_op = 3'd6;
        tick();
        chk("sim2_result", 32'(out_result), 32'b1001);
        chk("sim2_valid", 32'(out_valid), 32'd1);
        chk("sim2_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("sim_count", 32'(op_count), 32'd11);

        // Flags and illegal opcode
        in_valid = 1'b1; in_op = 3'd1; in_a = 4'b1111; in_b = 4'b1111;
        tick();
        chk("and_ones_flags", {out_zero, out_ones, out_parity, out_illegal}, 32'b0100);
        in_op = 3'd5; in_a = 4'b0101; in_b = 4'b0101;
        tick();
        chk("xor_zero_result", 32'(out_result), 32'd0);
        chk("xor_zero_flags", {out_zero, out_ones, out_parity, out_illegal}, 32'b1000);
        in_op = 3'd0; in_a = 4'b1110;
        tick();
        chk("not_parity_flags", {out_zero, out_ones, out_parity, out_illegal}, 32'b0010);
        in_op = 3'd7; in_a = 4'b1111; in_b = 4'b0110;
        tick();
        chk("ill_result", 32'(out_result), 32'd0);
        chk("ill_flags", {out_zero, out_ones, out_parity, out_illegal}, 32'b1001);
        chk("ill_op", 32'(out_op), 32'd7);
        in_valid = 1'b0;
        tick();
        chk("flags_count", 32'(op_count), 32'd15);

        // Counter wrap on the 2-bit instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("wrap_reset_count", 32'(op_count2), 32'd0);
        in_valid = 1'b1; in_op = 3'd0; in_a = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("wrap%0d", k), 32'(op_count2), 32'(exp_wrap[k]));
        end

        // Reset while FULL
        out_ready = 1'b0;
        tick();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        chk("fullrst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("fullrst_empty", 32'(out_valid), 32'd0);
        chk("fullrst_in_ready", 32'(in_ready), 32'd1);
        chk("fullrst_count", 32'(op_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
